// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder driving one gate-level full_adder cell.
// Operands shift out LSB first; the sum is assembled MSB-in and published on the DONE entry edge.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry_in,
  output logic o_s,
  output logic o_carry_out
);
  logic w_p;

  assign w_p         = i_a ^ i_b;
  assign o_s         = w_p ^ i_carry_in;
  assign o_carry_out = (i_a & i_b) | (i_carry_in & w_p);
endmodule

module serial_adder #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry_in,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_sum,
  output logic         o_carry_out
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_a_sh;
  logic [N-1:0]    r_b_sh;
  logic [N-1:0]    r_sum_sh;
  logic [N-1:0]    r_sum;
  logic            r_carry;
  logic            r_carry_out;
  logic [CW-1:0]   r_cnt;
  logic            w_fa_s;
  logic            w_fa_carry_out;
  logic            w_last;
  logic [N-1:0]    w_sum_next;

  full_adder u_full_adder (
    .i_a         (r_a_sh[0]),
    .i_b         (r_b_sh[0]),
    .i_carry_in  (r_carry),
    .o_s         (w_fa_s),
    .o_carry_out (w_fa_carry_out)
  );

  assign w_last = (r_cnt == CW'(N - 1));

  // A one-bit sum register has nothing to shift; the new bit simply replaces it.
  generate
    if (N == 1) begin : g_sum_1
      assign w_sum_next = w_fa_s;
    end else begin : g_sum_n
      assign w_sum_next = {w_fa_s, r_sum_sh[N-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_ADD;
        end
      end
      S_ADD: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_carry <= i_carry_in;
            r_cnt   <= '0;
          end
        end
        S_ADD: begin
          r_sum_sh <= w_sum_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_fa_carry_out;
          if (w_last) begin
            r_sum       <= w_sum_next;
            r_carry_out <= w_fa_carry_out;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_sum       = r_sum;
  assign o_carry_out = r_carry_out;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed scoreboard bench for serial_adder at N=8 and N=1.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut8 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start8),
    .i_a         (a8),
    .i_b         (b8),
    .i_carry_in  (cin8),
    .o_busy      (busy8),
    .o_done      (done8),
    .o_sum       (sum8),
    .o_carry_out (cout8)
  );

  serial_adder #(.N(1)) dut1 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start1),
    .i_a         (a1),
    .i_b         (b1),
    .i_carry_in  (cin1),
    .o_busy      (busy1),
    .o_done      (done1),
    .o_sum       (sum1),
    .o_carry_out (cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] prev;
    logic [8:0] exp;
    int         edges;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    prev   = {cout8, sum8};
    a8     = a;
    b8     = b;
    cin8   = c;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    cin8   = 1'($urandom);
    chk("busy_after_accept", busy8, 1);
    chk("sum_held_during_add", {cout8, sum8}, prev);
    edges = 0;
    while (!done8 && edges < 20) begin
      step();
      edges++;
    end
    chk("done_latency8", edges, 8);
    if (done8) begin
      exp = q8.pop_front();
      chk("result8", {cout8, sum8}, exp);
      chk("busy_in_done8", busy8, 1);
    end
    step();
    chk("done_single_cycle8", done8, 0);
    chk("busy_idle8", busy8, 0);
  endtask

  task automatic add1(input logic a, input logic b, input logic c);
    logic [1:0] exp;
    int         edges;
    q1.push_back({1'b0, a} + {1'b0, b} + {1'b0, c});
    a1     = a;
    b1     = b;
    cin1   = c;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("busy_after_accept1", busy1, 1);
    edges = 0;
    while (!done1 && edges < 10) begin
      step();
      edges++;
    end
    chk("done_latency1", edges, 1);
    if (done1) begin
      exp = q1.pop_front();
      chk("result1", {cout1, sum1}, exp);
    end
    step();
    chk("done_single_cycle1", done1, 0);
  endtask

  initial begin
    logic [8:0] exp;
    int         edges;
    int         done_seen;

    rst_n  = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;

    // 1: reset values, then idle with no start
    step();
    step();
    chk("rst_out8", {busy8, done8, cout8, sum8}, 0);
    chk("rst_out1", {busy1, done1, cout1, sum1}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_out8", {busy8, done8, cout8, sum8}, 0);
    end

    // 2 and 3: plain and wrapping additions
    add8(8'h5A, 8'h23, 1'b0);
    add8(8'hFF, 8'h01, 1'b0);
    add8(8'hFF, 8'hFF, 1'b1);
    add8(8'h00, 8'h00, 1'b1);

    // 4: start held through busy is ignored, then accepted in IDLE at edge N+2
    q8.push_back(9'h030);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    start8 = 1'b1;
    step();
    a8 = 8'hAA; b8 = 8'h55;
    edges = 0;
    while (!done8 && edges < 20) begin
      step();
      edges++;
    end
    chk("held_start_latency", edges, 8);
    if (done8) begin
      exp = q8.pop_front();
      chk("held_start_first", {cout8, sum8}, exp);
    end
    step();
    chk("held_start_idle_edge9", busy8, 0);
    q8.push_back(9'h0FF);
    step();
    start8 = 1'b0;
    chk("held_start_accept_edge10", busy8, 1);
    edges = 0;
    while (!done8 && edges < 20) begin
      step();
      edges++;
    end
    chk("held_start_second_latency", edges, 8);
    if (done8) begin
      exp = q8.pop_front();
      chk("held_start_second", {cout8, sum8}, exp);
    end
    step();

    // 5: reset mid-ADD aborts without a done pulse; next add is clean
    a8 = 8'hF0; b8 = 8'hF0; cin8 = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_async", {busy8, done8, cout8, sum8}, 0);
    step();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_outputs_zero", {cout8, sum8}, 0);
    add8(8'h01, 8'h01, 1'b0);

    // 6: N=1 instance, every input combination
    for (int v = 0; v < 8; v++) begin
      add1(v[2], v[1], v[0]);
    end

    chk("scoreboard_empty", q8.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
